// File: rtl/line_timing_gen.sv
// Per-line pixel timing generator: walks the active pixel column and
// handshakes pixels to the pattern datapath. It inserts horizontal blanking
// with a new_line pulse per line, and inserts vertical blanking once the
// downstream line counter flags end_frame.
module line_timing_gen #(
   parameter int unsigned ACTIVE_PIX = 32,
   parameter int unsigned COL_W      = 5,
   parameter int unsigned HBLANK     = 8,
   parameter int unsigned VBLANK     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enb,
   input  logic             pix_ready,
   input  logic             end_frame,
   output logic [COL_W-1:0] col,
   output logic             pix_valid,
   output logic             frame_start,
   output logic             new_line,
   output logic             line_cnt_en
);

   localparam int unsigned HCNT_W = 8;
   localparam int unsigned VCNT_W = 16;

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(ACTIVE_PIX - 1);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HBLANK - 1);
   localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(VBLANK - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2,
      S_VBLANK = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [COL_W-1:0]    col_q, col_nx;
   logic [HCNT_W-1:0]   hcnt, hcnt_nx;
   logic [VCNT_W-1:0]   vcnt, vcnt_nx;
   logic                first_line, first_line_nx;
   logic                hblank_last;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         col_q      <= '0;
         hcnt       <= '0;
         vcnt       <= '0;
         first_line <= 1'b1;
      end else begin
         state      <= state_nx;
         col_q      <= col_nx;
         hcnt       <= hcnt_nx;
         vcnt       <= vcnt_nx;
         first_line <= first_line_nx;
      end
   end

   // Next-state and counter update; enb low overrides every transition
   always_comb begin
      state_nx      = state;
      col_nx        = col_q;
      hcnt_nx       = hcnt;
      vcnt_nx       = vcnt;
      first_line_nx = first_line;

      if (!enb) begin
         state_nx      = S_IDLE;
         col_nx        = '0;
         hcnt_nx       = '0;
         vcnt_nx       = '0;
         first_line_nx = 1'b1;
      end else begin
         unique case (state)
            S_IDLE: begin
               state_nx      = S_ACTIVE;
               col_nx        = '0;
               first_line_nx = 1'b1;
            end
            S_ACTIVE: begin
               if (pix_ready) begin
                  if (col_q == COL_LAST) begin
                     state_nx      = S_HBLANK;
                     col_nx        = '0;
                     hcnt_nx       = '0;
                     first_line_nx = 1'b0;
                  end else begin
                     col_nx = col_q + COL_W'(1);
                  end
               end
            end
            S_HBLANK: begin
               if (hcnt == HCNT_LAST) begin
                  hcnt_nx = '0;
                  if (end_frame) begin
                     state_nx = S_VBLANK;
                     vcnt_nx  = '0;
                  end else begin
                     state_nx = S_ACTIVE;
                     col_nx   = '0;
                  end
               end else begin
                  hcnt_nx = hcnt + HCNT_W'(1);
               end
            end
            S_VBLANK: begin
               if (vcnt == VCNT_LAST) begin
                  state_nx      = S_ACTIVE;
                  col_nx        = '0;
                  vcnt_nx       = '0;
                  first_line_nx = 1'b1;
               end else begin
                  vcnt_nx = vcnt + VCNT_W'(1);
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Output decodes of registered state; end_frame only gates new_line
   assign hblank_last = (state == S_HBLANK) && (hcnt == HCNT_LAST);
   assign col         = col_q;
   assign pix_valid   = (state == S_ACTIVE);
   assign frame_start = (state == S_ACTIVE) && first_line && (col_q == '0);
   assign new_line    = hblank_last && !end_frame;
   assign line_cnt_en = (state == S_ACTIVE) || (state == S_HBLANK);

endmodule

// File: tb/tb_line_timing_gen.sv
// Bench for line_timing_gen: segment table for line-level scenarios, hand
// sequences for resets, and a closed-form frame model driven through a
// behavioural 5-bit line counter.
module tb_line_timing_gen;

   typedef struct packed {
      logic [4:0] col;
      logic       valid;
      logic       fs;
      logic       nl;
      logic       en;
   } out_t;

   typedef struct {
      out_t want;
      int   tag;
      int   idx;
   } sb_t;

   typedef struct {
      logic       enb;
      logic       rdy;
      logic       ef;
      int         n;
      logic [4:0] col0;
      logic       step;
      logic       valid;
      logic       fs;
      logic       nl;
      logic       en;
   } row_t;

   logic       clk;
   logic       rst_n;
   logic       enb;
   logic       pix_ready;
   logic       end_frame;
   logic [4:0] col;
   logic       pix_valid;
   logic       frame_start;
   logic       new_line;
   logic       line_cnt_en;

   logic       ef_force;
   logic       use_lc;
   logic [4:0] lc_cnt;

   sb_t  sb[$];
   row_t tbl[$];
   int   total;
   int   bad;

   line_timing_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enb         (enb),
      .pix_ready   (pix_ready),
      .end_frame   (end_frame),
      .col         (col),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .new_line    (new_line),
      .line_cnt_en (line_cnt_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream 5-bit line counter: counts new_line, cleared while disabled
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            lc_cnt <= 5'd0;
      else if (!line_cnt_en) lc_cnt <= 5'd0;
      else if (new_line)     lc_cnt <= lc_cnt + 5'd1;
   end

   assign end_frame = use_lc ? (lc_cnt == 5'd23) : ef_force;

   // Scoreboard check at the falling edge, away from the active edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         sb_t  e;
         out_t got;
         e   = sb.pop_front();
         got = {col, pix_valid, frame_start, new_line, line_cnt_en};
         total++;
         if (got !== e.want) begin
            bad++;
            $display("FAIL outputs tag=%0d idx=%0d got col=%0d v=%b fs=%b nl=%b en=%b want col=%0d v=%b fs=%b nl=%b en=%b",
                     e.tag, e.idx, got.col, got.valid, got.fs, got.nl, got.en,
                     e.want.col, e.want.valid, e.want.fs, e.want.nl, e.want.en);
         end
      end
   end

   task automatic drive(input logic r_n, input logic e, input logic r, input logic f,
                        input out_t w, input int tag, input int idx);
      sb_t s;
      @(posedge clk);
      #1;
      rst_n     = r_n;
      enb       = e;
      pix_ready = r;
      ef_force  = f;
      s.want = w;
      s.tag  = tag;
      s.idx  = idx;
      sb.push_back(s);
   endtask

   function automatic row_t mk(input logic e, input logic r, input logic f, input int n,
                               input int c0, input logic st, input logic v,
                               input logic fs, input logic nl, input logic en);
      row_t x;
      x.enb = e; x.rdy = r; x.ef = f; x.n = n;
      x.col0 = 5'(c0); x.step = st;
      x.valid = v; x.fs = fs; x.nl = nl; x.en = en;
      return x;
   endfunction

   // Independent frame model: 24 lines of 40 cycles, then 16 blank cycles
   function automatic out_t frame_exp(input int p);
      out_t x;
      int   f;
      int   ln;
      int   w;
      x  = '0;
      f  = p % 976;
      if (f < 960) begin
         ln      = f / 40;
         w       = f % 40;
         x.col   = (w < 32) ? 5'(w) : 5'd0;
         x.valid = (w < 32);
         x.fs    = (f == 0);
         x.nl    = (w == 39) && (ln != 23);
         x.en    = 1'b1;
      end
      return x;
   endfunction

   initial begin
      out_t zero;
      out_t w;
      zero      = '0;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      enb       = 1'b0;
      pix_ready = 1'b0;
      ef_force  = 1'b0;
      use_lc    = 1'b0;

      //            enb  rdy  ef   n   col0 st  v    fs   nl   en
      // line 1: frame start, free running
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 0, 31,  1, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  7,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 1));
      // line 2
      tbl.push_back(mk(1, 1, 0, 32,  0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  7,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 1));
      // line 3: three stall cycles at col 10
      tbl.push_back(mk(1, 1, 0, 10,  0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0,  3, 10, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1, 10, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0, 21, 11, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  7,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 1));
      // line 4: end_frame high but dropped before the last blank cycle
      tbl.push_back(mk(1, 1, 1, 32,  0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 1,  7,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 1));
      // line 5: no vertical blank; enb dropped for one cycle at col 20
      tbl.push_back(mk(1, 1, 0, 20,  0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 1, 0,  1, 20, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 0, 0));
      // restart: fresh frame
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 1, 0, 31,  1, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  7,  0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 1));
      // next line, stopped mid-blank by reset below
      tbl.push_back(mk(1, 1, 0, 32,  0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 0,  3,  0, 0, 0, 0, 0, 1));

      // reset held, then released with enb high (one IDLE cycle)
      drive(1'b0, 1'b0, 1'b0, 1'b0, zero, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, zero, 0, 1);
      drive(1'b1, 1'b1, 1'b1, 1'b0, zero, 0, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            w.col   = tbl[i].col0 + (tbl[i].step ? 5'(k) : 5'd0);
            w.valid = tbl[i].valid;
            w.fs    = tbl[i].fs;
            w.nl    = tbl[i].nl;
            w.en    = tbl[i].en;
            drive(1'b1, tbl[i].enb, tbl[i].rdy, tbl[i].ef, w, 1, i);
         end
      end

      // async reset mid horizontal blank: outputs drop within the cycle
      use_lc = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, zero, 0, 10);
      drive(1'b0, 1'b1, 1'b1, 1'b0, zero, 0, 11);
      drive(1'b1, 1'b1, 1'b1, 1'b0, zero, 0, 12);

      // two full frames against the integrated line counter
      for (int p = 0; p < 2 * 976 + 50; p++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, frame_exp(p), 2, p);
      end

      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
